// File: rtl/serial_adder_pkg.sv
// Shared types and sizing for the bit-serial adder.
package serial_adder_pkg;

    // Default operand/sum width.
    localparam int unsigned SA_WIDTH = 8;

    // Bit-counter width needed to index WIDTH serial steps.
    function automatic int unsigned sa_cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int unsigned SA_CNT_W = sa_cnt_w(SA_WIDTH);

    // Controller states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } sa_state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_8bit_full_adder_1bit.sv
// Combinational 1-bit full-adder cell, shared with the subtractor harness.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    logic w_axb;

    // Sum and carry of a single bit position.
    always_comb begin
        w_axb = a ^ b;
        s     = w_axb ^ cin;
        c     = (a & b) | (cin & w_axb);
    end

endmodule : full_adder_1bit

// File: rtl/serial_adder_8bit.sv
// Bit-serial unsigned adder: LSB-first, one bit per clock through one cell.
module serial_adder_8bit
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH,
    parameter int unsigned CNT_W = sa_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    sa_state_e        r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    // Single shared adder cell fed by the operand LSBs and the carry flop.
    full_adder_1bit u_fa (
        .a   (r_sh_a[0]),
        .b   (r_sh_b[0]),
        .cin (r_carry),
        .s   (w_s),
        .c   (w_c)
    );

    // Final serial step detection and next result word (new bit enters at MSB).
    always_comb begin
        w_last     = (r_cnt == CNT_W'(WIDTH - 1));
        w_res_next = {w_s, r_res[WIDTH-1:1]};
    end

    // Controller, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_res       <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_sh_a     <= a;
                        r_sh_b     <= b;
                        r_carry    <= cin;
                        r_cnt      <= '0;
                        r_res      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ADD;
                    end
                end

                S_ADD: begin
                    r_res   <= w_res_next;
                    r_sh_a  <= {1'b0, r_sh_a[WIDTH-1:1]};
                    r_sh_b  <= {1'b0, r_sh_b[WIDTH-1:1]};
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_sum       <= w_res_next;
                        r_cout      <= w_c;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    // Result held until the consumer takes it; sum/cout keep value after.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule : serial_adder_8bit
